// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with the sign fix-up applied when the result register is loaded.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   kill                abort any operation and drop its result
//   in_valid, in_ready  request handshake (in_ready high only when idle)
//   op, a, b            RV32M funct3 and operands, latched on accept
//   out_valid, out_ready result handshake; result held until consumed
//   result              registered product / quotient / remainder
module alu_muldiv #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [XLEN-1:0]  MinVal  = {1'b1, {(XLEN - 1){1'b0}}};
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode on the request inputs.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;
    logic            div_zero, div_ovf;

    always_comb begin
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        mag_a    = a_neg ? (-a) : a;
        mag_b    = b_neg ? (-b) : b;
        div_zero = op[2] && (b == '0);
        // Only the signed forms (DIV, REM) can overflow.
        div_ovf  = op[2] && !op[0] && (a == MinVal) && (b == '1);
        if (div_zero) begin
            spec_res = op[1] ? a : '1;
        end else begin
            spec_res = op[1] ? '0 : a;
        end
    end

    // One iteration step. acc holds {hi, lo}: for multiply hi is the partial product and lo
    // the remaining multiplier bits; for divide hi is the partial remainder and lo shifts
    // dividend bits out while quotient bits shift in.
    logic [XLEN:0]     mul_sum, div_hi;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   q_fix, r_fix, fin;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_hi   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = div_hi >= {1'b0, mcand_q};
        div_diff = div_hi[XLEN-1:0] - mcand_q;
        if (op_q[2]) begin
            step = {(div_ge ? div_diff : div_hi[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod  = neg_q ? (-step) : step;
        q_fix = neg_q ? (-step[XLEN-1:0]) : step[XLEN-1:0];
        r_fix = neg_q ? (-step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];
        if (!op_q[2]) begin
            fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fin = op_q[1] ? r_fix : q_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        result_d  = result_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_d   = StCalc;
                        cnt_d     = '0;
                        op_d      = op;
                        mcand_d   = mag_b;
                        special_d = div_zero || div_ovf;
                        if (div_zero || div_ovf) begin
                            // Special results carry no sign fix-up; park them in acc.
                            acc_d = {{XLEN{1'b0}}, spec_res};
                            neg_d = 1'b0;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, mag_a};
                            neg_d = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                        end
                    end
                end
                StCalc: begin
                    if (special_q) begin
                        result_d = acc_q[XLEN-1:0];
                        state_d  = StDone;
                    end else begin
                        acc_d = step;
                        if (cnt_q == LastCnt) begin
                            result_d = fin;
                            state_d  = StDone;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule
